dca_matrix_row_requester: RTL and testbench

- Downstream stage of the DCA matrix block splitter.
- Accepts one block descriptor per handshake: base byte address, stride in bits, rows-1, cols-1, log2 element bit-size.
- Emits one memory-load request per valid row of the block, with byte address, bit offset, row bit count and byte length, in the form the LSU request queue consumes.
- Signals completion of each block so the splitter can advance (iterate/go_next_base).

---
 rtl/dca_matrix_row_requester.sv | 121 ++++++++++++
 tb/tb_dca_matrix_row_requester.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dca_matrix_row_requester.sv
// DCA matrix row requester: turns one block descriptor into one
// LSU load request per row, then pulses blk_done on the last row.
module dca_matrix_row_requester #(
    parameter int MATRIX_SIZE_PARA = 8,
    parameter int BW_ADDR          = 32,
    parameter int BW_STRIDE        = 20,
    parameter int BW_LEN           = 16,
    localparam int BW_IDX =
        (MATRIX_SIZE_PARA > 2) ? $clog2(MATRIX_SIZE_PARA) : 1
) (
    input  logic                 clk,
    input  logic                 rstnn,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 blk_valid,
    output logic                 blk_ready,
    input  logic [BW_ADDR-1:0]   blk_addr,
    input  logic [BW_STRIDE-1:0] blk_stride_ls3,
    input  logic [BW_IDX-1:0]    blk_num_row_m1,
    input  logic [BW_IDX-1:0]    blk_num_col_m1,
    input  logic [2:0]           blk_elem_lsa_p3,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [BW_ADDR-1:0]   req_addr,
    output logic [2:0]           req_bit_offset,
    output logic [BW_LEN-1:0]    req_num_bits,
    output logic [BW_LEN-1:0]    req_len_bytes,
    output logic [BW_IDX-1:0]    req_row,
    output logic                 req_last,
    output logic                 blk_done
);

    localparam int BW_BADDR = BW_ADDR + 3;

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_t;

    state_t                r_state;
    logic [BW_IDX-1:0]     r_row;
    logic [BW_BADDR-1:0]   r_baddr;
    logic [BW_STRIDE-1:0]  r_stride;
    logic [BW_IDX-1:0]     r_row_m1;
    logic [BW_IDX:0]       r_cols;
    logic [2:0]            r_lsa;

    logic                  w_issue;
    logic                  w_row_end;
    logic                  w_fire;
    logic [BW_BADDR-1:0]   w_stride_ext;
    logic [BW_LEN-1:0]     w_cols;
    logic [BW_LEN-1:0]     w_num_bits;
    logic [BW_LEN+3:0]     w_len_sum;

    assign w_issue      = (r_state == S_ISSUE);
    assign w_row_end    = (r_row == r_row_m1);
    assign w_fire       = req_valid & req_ready;
    assign w_stride_ext = BW_BADDR'(r_stride);

    // Cols are stored as a count (not minus one) so reset leaves every
    // derived request field at zero.
    assign w_cols     = BW_LEN'(r_cols);
    assign w_num_bits = w_cols << r_lsa;
    assign w_len_sum  = (BW_LEN+4)'(w_num_bits)
                      + (BW_LEN+4)'(r_baddr[2:0])
                      + (BW_LEN+4)'(7);

    assign blk_ready      = enable & (r_state == S_IDLE);
    assign req_valid      = enable & w_issue;
    assign req_addr       = r_baddr[BW_BADDR-1:3];
    assign req_bit_offset = r_baddr[2:0];
    assign req_num_bits   = w_num_bits;
    assign req_len_bytes  = w_len_sum[BW_LEN+2:3];
    assign req_row        = r_row;
    assign req_last       = w_issue & w_row_end;
    assign blk_done       = w_fire & req_last;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_state  <= S_IDLE;
            r_row    <= '0;
            r_baddr  <= '0;
            r_stride <= '0;
            r_row_m1 <= '0;
            r_cols   <= '0;
            r_lsa    <= '0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_baddr <= '0;
        end else if (enable) begin
            unique case (r_state)
                S_IDLE: begin
                    if (blk_valid) begin
                        r_stride <= blk_stride_ls3;
                        r_row_m1 <= blk_num_row_m1;
                        r_cols   <= (BW_IDX+1)'(blk_num_col_m1)
                                  + (BW_IDX+1)'(1);
                        r_lsa    <= blk_elem_lsa_p3;
                        r_baddr  <= {blk_addr, 3'b000};
                        r_row    <= '0;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (req_ready) begin
                        if (w_row_end) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_row   <= r_row + 1'b1;
                            r_baddr <= r_baddr + w_stride_ext;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dca_matrix_row_requester.sv
// Directed bench for dca_matrix_row_requester with a request
// scoreboard filled at descriptor time and drained on handshakes.
module tb_dca_matrix_row_requester;

    logic        clk = 1'b0;
    logic        rstnn;
    logic        clear;
    logic        enable;
    logic        blk_valid;
    logic        blk_ready;
    logic [31:0] blk_addr;
    logic [19:0] blk_stride_ls3;
    logic [2:0]  blk_num_row_m1;
    logic [2:0]  blk_num_col_m1;
    logic [2:0]  blk_elem_lsa_p3;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_bit_offset;
    logic [15:0] req_num_bits;
    logic [15:0] req_len_bytes;
    logic [2:0]  req_row;
    logic        req_last;
    logic        blk_done;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  off;
        logic [15:0] bits;
        logic [15:0] len;
        logic [2:0]  row;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    dca_matrix_row_requester dut (
        .clk             (clk),
        .rstnn           (rstnn),
        .clear           (clear),
        .enable          (enable),
        .blk_valid       (blk_valid),
        .blk_ready       (blk_ready),
        .blk_addr        (blk_addr),
        .blk_stride_ls3  (blk_stride_ls3),
        .blk_num_row_m1  (blk_num_row_m1),
        .blk_num_col_m1  (blk_num_col_m1),
        .blk_elem_lsa_p3 (blk_elem_lsa_p3),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_bit_offset  (req_bit_offset),
        .req_num_bits    (req_num_bits),
        .req_len_bytes   (req_len_bytes),
        .req_row         (req_row),
        .req_last        (req_last),
        .blk_done        (blk_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_blk(input logic [31:0] a,
                                     input logic [19:0] s,
                                     input int rm1, input int cm1,
                                     input int lsa);
        logic [34:0] ba;
        exp_t        e;
        ba = {a, 3'b000};
        for (int r = 0; r <= rm1; r++) begin
            e.addr = ba[34:3];
            e.off  = ba[2:0];
            e.bits = 16'((cm1 + 1) << lsa);
            e.len  = 16'((int'(e.off) + int'(e.bits) + 7) / 8);
            e.row  = 3'(r);
            e.last = (r == rm1);
            q.push_back(e);
            ba = ba + 35'(s);
        end
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_blk(input logic [31:0] a, input logic [19:0] s,
                             input int rm1, input int cm1, input int lsa);
        blk_addr        = a;
        blk_stride_ls3  = s;
        blk_num_row_m1  = 3'(rm1);
        blk_num_col_m1  = 3'(cm1);
        blk_elem_lsa_p3 = 3'(lsa);
        blk_valid       = 1'b1;
    endtask

    task automatic send(input logic [31:0] a, input logic [19:0] s,
                        input int rm1, input int cm1, input int lsa);
        logic acc = 1'b0;
        push_blk(a, s, rm1, cm1, lsa);
        drive_blk(a, s, rm1, cm1, lsa);
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            if (blk_ready) acc = 1'b1;
            sync();
        end
        blk_valid = 1'b0;
        chk("accept", 64'(acc), 64'd1);
    endtask

    task automatic drain(input int maxc);
        for (int n = 0; n < maxc && q.size() > 0; n++) @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    // Scoreboard: each handshake must match the oldest expected row.
    always @(negedge clk) begin
        if (rstnn && req_valid && req_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_req", {32'd0, req_addr}, 64'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("req_addr", 64'(req_addr), 64'(e.addr));
                chk("req_off", 64'(req_bit_offset), 64'(e.off));
                chk("req_bits", 64'(req_num_bits), 64'(e.bits));
                chk("req_len", 64'(req_len_bytes), 64'(e.len));
                chk("req_row", 64'(req_row), 64'(e.row));
                chk("req_last", 64'(req_last), 64'(e.last));
                chk("blk_done", 64'(blk_done), 64'(e.last));
            end
        end
        if (rstnn && blk_done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int   d0;
        logic prev_stall;
        logic [31:0] h_addr;
        logic [2:0]  h_row;
        logic [2:0]  h_off;
        logic [15:0] h_bits;
        bit   pat[5];

        rstnn = 1'b0;
        clear = 1'b0;
        enable = 1'b1;
        blk_valid = 1'b0;
        req_ready = 1'b1;
        blk_addr = '0;
        blk_stride_ls3 = '0;
        blk_num_row_m1 = '0;
        blk_num_col_m1 = '0;
        blk_elem_lsa_p3 = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_req_addr", 64'(req_addr), 64'd0);
        chk("rst_num_bits", 64'(req_num_bits), 64'd0);
        chk("rst_len", 64'(req_len_bytes), 64'd0);
        chk("rst_last", 64'(req_last), 64'd0);
        chk("rst_done", 64'(blk_done), 64'd0);
        rstnn = 1'b1;
        @(negedge clk);
        chk("rst_blk_ready", 64'(blk_ready), 64'd1);
        sync();

        // Dense 32-bit block
        d0 = done_cnt;
        send(32'h1000, 20'd512, 3, 7, 5);
        @(negedge clk);
        chk("t1_valid", 64'(req_valid), 64'd1);
        chk("t1_bits", 64'(req_num_bits), 64'd256);
        chk("t1_len", 64'(req_len_bytes), 64'd32);
        drain(20);
        chk("t1_ready_after", 64'(blk_ready), 64'd1);
        chk("t1_done_cnt", 64'(done_cnt), 64'(d0 + 1));
        sync();

        // Sub-byte rows
        send(32'h2000, 20'd12, 2, 2, 2);
        drain(20);
        sync();

        // Backpressure with ready pattern 1,0,0,...
        send(32'h1000, 20'd512, 3, 7, 5);
        prev_stall = 1'b0;
        h_addr = '0; h_row = '0; h_off = '0; h_bits = '0;
        for (int i = 0; i < 40 && q.size() > 0; i++) begin
            req_ready = (i % 3 == 0);
            @(negedge clk);
            if (prev_stall) begin
                chk("bp_addr", 64'(req_addr), 64'(h_addr));
                chk("bp_row", 64'(req_row), 64'(h_row));
                chk("bp_off", 64'(req_bit_offset), 64'(h_off));
                chk("bp_bits", 64'(req_num_bits), 64'(h_bits));
            end
            prev_stall = req_valid && !req_ready;
            h_addr = req_addr;
            h_row  = req_row;
            h_off  = req_bit_offset;
            h_bits = req_num_bits;
            sync();
        end
        chk("bp_empty", 64'(q.size()), 64'd0);
        req_ready = 1'b1;
        sync();

        // Address wrap
        send(32'hFFFF_FFC0, 20'd512, 1, 7, 5);
        drain(20);
        sync();

        // clear after second handshake
        send(32'h1000, 20'd512, 3, 7, 5);
        @(posedge clk);
        @(posedge clk);
        #1;
        req_ready = 1'b0;
        clear = 1'b1;
        d0 = done_cnt;
        sync();
        clear = 1'b0;
        @(negedge clk);
        chk("clr_valid", 64'(req_valid), 64'd0);
        chk("clr_ready", 64'(blk_ready), 64'd1);
        chk("clr_left", 64'(q.size()), 64'd2);
        q.delete();
        req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("clr_quiet", 64'(req_valid), 64'd0);
        end
        chk("clr_no_done", 64'(done_cnt), 64'(d0));
        sync();

        // Descriptor presented with clear is dropped
        drive_blk(32'h1000, 20'd512, 3, 7, 5);
        clear = 1'b1;
        sync();
        clear = 1'b0;
        blk_valid = 1'b0;
        @(negedge clk);
        chk("clr_noacc", 64'(req_valid), 64'd0);
        sync();

        // enable low for three cycles mid-block
        send(32'h1000, 20'd512, 3, 7, 5);
        sync();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("en_valid", 64'(req_valid), 64'd0);
            chk("en_ready", 64'(blk_ready), 64'd0);
            chk("en_row", 64'(req_row), 64'd1);
            sync();
        end
        enable = 1'b1;
        @(negedge clk);
        chk("en_resume_v", 64'(req_valid), 64'd1);
        chk("en_resume_row", 64'(req_row), 64'd1);
        chk("en_resume_addr", 64'(req_addr), 64'h1040);
        drain(20);
        sync();

        // Back-to-back descriptors held valid
        push_blk(32'h3000, 20'd64, 0, 3, 3);
        push_blk(32'h4000, 20'd128, 1, 1, 4);
        d0 = done_cnt;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        drive_blk(32'h3000, 20'd64, 0, 3, 3);
        @(negedge clk);
        chk("b2b_ready0", 64'(blk_ready), 64'd1);
        sync();
        drive_blk(32'h4000, 20'd128, 1, 1, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b2b_valid", 64'(req_valid), 64'(pat[i]));
            sync();
            if (i == 1) blk_valid = 1'b0;
        end
        chk("b2b_done", 64'(done_cnt), 64'(d0 + 2));
        chk("b2b_empty", 64'(q.size()), 64'd0);

        // Asynchronous reset mid-block
        send(32'h1000, 20'd512, 3, 7, 5);
        sync();
        rstnn = 1'b0;
        #1;
        chk("arst_valid", 64'(req_valid), 64'd0);
        chk("arst_addr", 64'(req_addr), 64'd0);
        chk("arst_row", 64'(req_row), 64'd0);
        q.delete();
        sync();
        rstnn = 1'b1;
        @(negedge clk);
        chk("arst_ready", 64'(blk_ready), 64'd1);
        chk("arst_idle", 64'(req_valid), 64'd0);
        sync();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
